quad_encoder_tx: RTL and testbench

//  Quadrature encoder emitter, the transmit side of the paddle A/B input path.

---
 rtl/pong_pkg.sv | 28 ++
 rtl/quad_encoder_tx_if.sv | 36 +++
 rtl/quad_dwell_timer.sv | 37 +++
 rtl/quad_encoder_tx.sv | 129 ++++++++++++
 tb/tb_quad_encoder_tx.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// ============================================================================
// Module : pong_pkg
// Brief  : Quadrature phase table and direction constants shared by the
//          paddle encoder and decoder paths.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pong_pkg;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  // {a,b} for phase index i sits at bits [2i+1:2i]: 0=00, 1=10, 2=11, 3=01
  localparam logic [7:0] QUAD_PHASE = 8'b01_11_10_00;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } qe_state_t;

  function automatic logic [1:0] quad_phase(input logic [1:0] idx);
    return QUAD_PHASE[{idx, 1'b0} +: 2];
  endfunction

endpackage

`default_nettype wire

// File: rtl/quad_encoder_tx_if.sv
// ============================================================================
// Module : quad_encoder_tx_if
// Brief  : Command handshake and quadrature output bundle of the encoder.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface quad_encoder_tx_if #(
  parameter int CNT_W = 10,
  parameter int POS_W = 10
);

  logic             step_valid;
  logic             step_ready;
  logic             step_dir;
  logic [CNT_W-1:0] step_count;
  logic             abort;
  logic             a;
  logic             b;
  logic             busy;
  logic             done;
  logic [POS_W-1:0] position;

  modport master (
    output step_valid, step_dir, step_count, abort,
    input  step_ready, a, b, busy, done, position
  );

  modport slave (
    input  step_valid, step_dir, step_count, abort,
    output step_ready, a, b, busy, done, position
  );

endinterface

`default_nettype wire

// File: rtl/quad_dwell_timer.sv
// ============================================================================
// Module : quad_dwell_timer
// Brief  : Down-counter timing the hold period of each A/B state.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module quad_dwell_timer #(
  parameter int DWELL_CYCLES = 4
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_clear,
  input  wire logic i_load,
  output logic      o_expire
);

  localparam int TW = $clog2(DWELL_CYCLES + 1);

  logic [TW-1:0] r_cnt;

  // Loading DWELL_CYCLES-1 on an edge makes expiry land on the last held cycle
  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= TW'(DWELL_CYCLES - 1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expire = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/quad_encoder_tx.sv
// ============================================================================
// Module : quad_encoder_tx
// Brief  : Quadrature encoder emitter: step commands in, dwell-paced Gray A/B out.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module quad_encoder_tx
  import pong_pkg::*;
#(
  parameter int DWELL_CYCLES = 4,
  parameter int CNT_W        = 10,
  parameter int POS_W        = 10
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  quad_encoder_tx_if.slave   bus
);

  qe_state_t        r_state;
  qe_state_t        w_state_nxt;
  logic [1:0]       r_phase;
  logic             r_a;
  logic             r_b;
  logic             r_dir;
  logic             r_done;
  logic [CNT_W-1:0] r_remain;
  logic [POS_W-1:0] r_pos;

  logic             w_accept;
  logic             w_edge;
  logic             w_edge_dir;
  logic             w_load;
  logic             w_clear;
  logic             w_done_nxt;
  logic             w_expire;
  logic [1:0]       w_phase_nxt;

  quad_dwell_timer #(
    .DWELL_CYCLES (DWELL_CYCLES)
  ) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_clear),
    .i_load   (w_load),
    .o_expire (w_expire)
  );

  // The first edge of a command is emitted on the accept edge itself
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_edge      = 1'b0;
    w_edge_dir  = r_dir;
    w_load      = 1'b0;
    w_clear     = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.step_valid && !bus.abort) begin
          w_accept = 1'b1;
          if (bus.step_count == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_RUN;
            w_edge      = 1'b1;
            w_edge_dir  = bus.step_dir;
            w_load      = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
          w_clear     = 1'b1;
        end else if (w_expire) begin
          if (r_remain == '0) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_edge = 1'b1;
            w_load = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_phase_nxt = (w_edge_dir == DIR_FWD) ? r_phase + 2'd1 : r_phase - 2'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_phase  <= 2'd0;
      r_a      <= 1'b0;
      r_b      <= 1'b0;
      r_dir    <= DIR_FWD;
      r_done   <= 1'b0;
      r_remain <= '0;
      r_pos    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      if (w_accept) begin
        r_dir    <= bus.step_dir;
        r_remain <= bus.step_count - 1'b1;
      end else if (w_edge) begin
        r_remain <= r_remain - 1'b1;
      end
      if (w_edge) begin
        r_phase    <= w_phase_nxt;
        {r_a, r_b} <= quad_phase(w_phase_nxt);
        r_pos      <= (w_edge_dir == DIR_FWD) ? r_pos + 1'b1 : r_pos - 1'b1;
      end
    end
  end

  assign bus.step_ready = (r_state == ST_IDLE);
  assign bus.busy       = (r_state == ST_RUN);
  assign bus.done       = r_done;
  assign bus.a          = r_a;
  assign bus.b          = r_b;
  assign bus.position   = r_pos;

endmodule

`default_nettype wire

// File: tb/tb_quad_encoder_tx.sv
// ============================================================================
// Module : tb_quad_encoder_tx
// Brief  : Directed self-checking bench for quad_encoder_tx with a paddle
//          decoder model on the A/B outputs.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_quad_encoder_tx;

  localparam int DW = 4;
  localparam int CW = 10;
  localparam int PW = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  quad_encoder_tx_if #(.CNT_W(CW), .POS_W(PW)) bus ();

  quad_encoder_tx #(
    .DWELL_CYCLES (DW),
    .CNT_W        (CW),
    .POS_W        (PW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [1:0] ab2idx(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'd0;
      2'b10:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  // Edge monitor + paddle decoder: one-bit change, minimum dwell, decoded count
  logic          mon_en = 1'b0;
  logic [1:0]    mon_prev;
  int            mon_gap;
  logic [PW-1:0] dec_pos;

  always @(negedge clk) begin
    if (!rst_n || !mon_en) begin
      mon_prev = {bus.a, bus.b};
      mon_gap  = DW;
      dec_pos  = '0;
    end else begin
      mon_gap++;
      if ({bus.a, bus.b} !== mon_prev) begin
        n_checks++;
        if (mon_gap < DW || ^({bus.a, bus.b} ^ mon_prev) !== 1'b1) begin
          n_fail++;
          $display("FAIL edge_rule: ab %b->%b after %0d cycles, required one-bit change after >= %0d",
                   mon_prev, {bus.a, bus.b}, mon_gap, DW);
        end
        if (ab2idx({bus.a, bus.b}) == ab2idx(mon_prev) + 2'd1) dec_pos++;
        else dec_pos--;
        mon_prev = {bus.a, bus.b};
        mon_gap  = 0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  // Called at a sample point; returns at the sample point of cycle T+1
  task automatic issue(input logic dir, input logic [CW-1:0] cnt);
    bus.step_valid = 1'b1;
    bus.step_dir   = dir;
    bus.step_count = cnt;
    @(posedge clk);
    @(negedge clk);
    bus.step_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if ({bus.a, bus.b, bus.busy, bus.done, bus.step_ready} !== 5'b00001) begin n_fail++;
      $display("FAIL reset_ctl: a,b,busy,done,ready=%b required 00001", {bus.a, bus.b, bus.busy, bus.done, bus.step_ready}); end
    n_checks++; if (bus.position !== 10'd0) begin n_fail++;
      $display("FAIL reset_pos: position=%0d required 0", bus.position); end
  endtask

  task automatic test_forward();
    issue(1'b1, 10'd4);
    n_checks++; if ({bus.a, bus.b, bus.busy, bus.step_ready} !== 4'b1010) begin n_fail++;
      $display("FAIL fwd_t1: a,b,busy,ready=%b required 1010", {bus.a, bus.b, bus.busy, bus.step_ready}); end
    n_checks++; if (bus.position !== 10'd1) begin n_fail++;
      $display("FAIL fwd_t1_pos: position=%0d required 1", bus.position); end
    step(4);
    n_checks++; if ({bus.a, bus.b} !== 2'b11) begin n_fail++;
      $display("FAIL fwd_t5: ab=%b required 11", {bus.a, bus.b}); end
    step(4);
    n_checks++; if ({bus.a, bus.b} !== 2'b01) begin n_fail++;
      $display("FAIL fwd_t9: ab=%b required 01", {bus.a, bus.b}); end
    step(4);
    n_checks++; if ({bus.a, bus.b} !== 2'b00 || bus.position !== 10'd4) begin n_fail++;
      $display("FAIL fwd_t13: ab=%b pos=%0d required 00 pos=4", {bus.a, bus.b}, bus.position); end
    step(3);
    n_checks++; if ({bus.done, bus.busy} !== 2'b01) begin n_fail++;
      $display("FAIL fwd_t16: done,busy=%b required 01", {bus.done, bus.busy}); end
    step(1);
    n_checks++; if ({bus.done, bus.busy, bus.step_ready} !== 3'b101 || bus.position !== 10'd4) begin n_fail++;
      $display("FAIL fwd_t17: done,busy,ready=%b pos=%0d required 101 pos=4",
               {bus.done, bus.busy, bus.step_ready}, bus.position); end
  endtask

  // Accepted in the done cycle of the previous command
  task automatic test_back_to_back();
    issue(1'b0, 10'd2);
    n_checks++; if ({bus.a, bus.b} !== 2'b01 || bus.position !== 10'd3) begin n_fail++;
      $display("FAIL b2b_e0: ab=%b pos=%0d required 01 pos=3", {bus.a, bus.b}, bus.position); end
    step(3);
    n_checks++; if ({bus.a, bus.b} !== 2'b01) begin n_fail++;
      $display("FAIL b2b_hold: ab=%b required 01", {bus.a, bus.b}); end
    step(1);
    n_checks++; if ({bus.a, bus.b} !== 2'b11 || bus.position !== 10'd2) begin n_fail++;
      $display("FAIL b2b_e1: ab=%b pos=%0d required 11 pos=2", {bus.a, bus.b}, bus.position); end
    step(4);
    n_checks++; if (bus.done !== 1'b1) begin n_fail++;
      $display("FAIL b2b_done: done=%b required 1", bus.done); end
  endtask

  task automatic test_wrap();
    do_reset();
    issue(1'b0, 10'd1);
    n_checks++; if ({bus.a, bus.b} !== 2'b01 || bus.position !== 10'd1023) begin n_fail++;
      $display("FAIL wrap_rev: ab=%b pos=%0d required 01 pos=1023", {bus.a, bus.b}, bus.position); end
    step(4);
    n_checks++; if (bus.done !== 1'b1) begin n_fail++;
      $display("FAIL wrap_rev_done: done=%b required 1", bus.done); end
    issue(1'b1, 10'd1);
    n_checks++; if ({bus.a, bus.b} !== 2'b00 || bus.position !== 10'd0) begin n_fail++;
      $display("FAIL wrap_fwd: ab=%b pos=%0d required 00 pos=0", {bus.a, bus.b}, bus.position); end
    step(4);
  endtask

  task automatic test_zero_count();
    step(2);
    issue(1'b1, 10'd0);
    n_checks++; if ({bus.done, bus.busy, bus.a, bus.b} !== 4'b1000 || bus.position !== 10'd0) begin n_fail++;
      $display("FAIL zero_t1: done,busy,a,b=%b pos=%0d required 1000 pos=0",
               {bus.done, bus.busy, bus.a, bus.b}, bus.position); end
    step(1);
    n_checks++; if ({bus.done, bus.busy, bus.step_ready} !== 3'b001) begin n_fail++;
      $display("FAIL zero_t2: done,busy,ready=%b required 001", {bus.done, bus.busy, bus.step_ready}); end
  endtask

  task automatic test_abort();
    step(1);
    issue(1'b1, 10'd10);
    step(4);
    n_checks++; if ({bus.a, bus.b} !== 2'b11 || bus.position !== 10'd2) begin n_fail++;
      $display("FAIL abort_pre: ab=%b pos=%0d required 11 pos=2", {bus.a, bus.b}, bus.position); end
    step(1);
    bus.abort = 1'b1;
    step(1);
    bus.abort = 1'b0;
    n_checks++; if ({bus.done, bus.busy, bus.step_ready, bus.a, bus.b} !== 5'b10111) begin n_fail++;
      $display("FAIL abort_t7: done,busy,ready,a,b=%b required 10111",
               {bus.done, bus.busy, bus.step_ready, bus.a, bus.b}); end
    step(6);
    n_checks++; if ({bus.a, bus.b, bus.done} !== 3'b110 || bus.position !== 10'd2) begin n_fail++;
      $display("FAIL abort_frozen: a,b,done=%b pos=%0d required 110 pos=2",
               {bus.a, bus.b, bus.done}, bus.position); end
    // abort in the cycle where the next edge was due
    issue(1'b1, 10'd5);
    step(3);
    bus.abort = 1'b1;
    step(1);
    bus.abort = 1'b0;
    n_checks++; if ({bus.a, bus.b, bus.done} !== 3'b011 || bus.position !== 10'd3) begin n_fail++;
      $display("FAIL abort_suppress: a,b,done=%b pos=%0d required 011 pos=3",
               {bus.a, bus.b, bus.done}, bus.position); end
    step(5);
    issue(1'b0, 10'd10);
    n_checks++; if ({bus.a, bus.b} !== 2'b11 || bus.position !== 10'd2) begin n_fail++;
      $display("FAIL midrst_pre: ab=%b pos=%0d required 11 pos=2", {bus.a, bus.b}, bus.position); end
    step(2);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    n_checks++; if ({bus.a, bus.b, bus.busy, bus.done, bus.step_ready} !== 5'b00001 || bus.position !== 10'd0) begin n_fail++;
      $display("FAIL midrst: a,b,busy,done,ready=%b pos=%0d required 00001 pos=0",
               {bus.a, bus.b, bus.busy, bus.done, bus.step_ready}, bus.position); end
  endtask

  task automatic test_loopback();
    logic [PW-1:0] exp_pos = '0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      logic          d;
      logic [CW-1:0] c;
      int            waited;
      d = 1'($urandom_range(0, 1));
      c = CW'($urandom_range(0, 6));
      exp_pos = d ? exp_pos + PW'(c) : exp_pos - PW'(c);
      issue(d, c);
      waited = 0;
      while (bus.done !== 1'b1 && waited < int'(c) * DW + 5) begin
        step(1);
        waited++;
      end
      n_checks++; if (bus.done !== 1'b1) begin n_fail++;
        $display("FAIL loop_timeout: cmd %0d done=%b required 1 within %0d cycles", i, bus.done, waited); end
      n_checks++; if (bus.position !== exp_pos || dec_pos !== exp_pos) begin n_fail++;
        $display("FAIL loop_pos: cmd %0d position=%0d decoded=%0d required %0d", i, bus.position, dec_pos, exp_pos); end
    end
  endtask

  initial begin
    bus.step_valid = 1'b0;
    bus.step_dir   = 1'b0;
    bus.step_count = '0;
    bus.abort      = 1'b0;
    test_reset();
    test_forward();
    test_back_to_back();
    test_wrap();
    test_zero_count();
    test_abort();
    test_loopback();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
